// File: rtl/alu_mode_pkg.sv
// alu_mode_pkg: select encodings and default sizing shared by the ALU mode controller.
`default_nettype none

package alu_mode_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam int DEFAULT_WIDTH           = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, stability counter and rising-edge pulse for one button.
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  // Any return to the accepted level clears the count, so bounces restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = db & ~db_q;

endmodule

`default_nettype wire

// File: rtl/alu_mode_controller.sv
// alu_mode_controller: debounced button toggles pick which ALU bus drives the registered output F.
// Optional auto-scan stepping of the select is enabled with `define ALU_MODE_AUTO_SCAN_EN.
`default_nettype none

module alu_mode_controller
  import alu_mode_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SCAN_PERIOD     = 50000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       BTN,
`ifdef ALU_MODE_AUTO_SCAN_EN
  input  logic             SCAN,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [1:0]       SEL,
  output logic             SEL_CHG,
  output logic [WIDTH-1:0] F
);

  logic [1:0] rise;
  sel_t       next_sel;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (CLK),
      .rst (RST),
      .btn (BTN[i]),
      .rise(rise[i])
    );
  end

`ifdef ALU_MODE_AUTO_SCAN_EN
  localparam int PW = $clog2(SCAN_PERIOD) + 1;
  localparam logic [PW-1:0] PLAST = PW'(SCAN_PERIOD - 1);

  logic          scan_s1;
  logic          scan_s2;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] next_pcnt;

  // A button toggle landing on a scan step suppresses the step; the period restarts either way.
  always_comb begin
    next_sel  = SEL ^ rise;
    next_pcnt = pcnt;
    if (!scan_s2) begin
      next_pcnt = '0;
    end else if (pcnt == PLAST) begin
      next_pcnt = '0;
      if (rise == 2'b00) next_sel = SEL + 2'b01;
    end else begin
      next_pcnt = pcnt + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_s1 <= 1'b0;
      scan_s2 <= 1'b0;
      pcnt    <= '0;
    end else begin
      scan_s1 <= SCAN;
      scan_s2 <= scan_s1;
      pcnt    <= next_pcnt;
    end
  end
`else
  always_comb begin
    next_sel = SEL ^ rise;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL     <= SEL_A;
      SEL_CHG <= 1'b0;
      F       <= '0;
    end else begin
      SEL     <= next_sel;
      SEL_CHG <= (next_sel != SEL);
      // Mux uses the current select, so F trails SEL by one cycle.
      case (SEL)
        SEL_A:   F <= A;
        SEL_B:   F <= B;
        SEL_C:   F <= C;
        default: F <= D;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mode_controller.sv
// tb_alu_mode_controller: table-driven press vectors with a scoreboard, plus reset/bounce sequences.
`default_nettype none

module tb_alu_mode_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] BTN = 2'b00;
`ifdef ALU_MODE_AUTO_SCAN_EN
  logic       SCAN = 1'b0;
`endif
  logic [9:0] A = 10'h001;
  logic [9:0] B = 10'h002;
  logic [9:0] C = 10'h004;
  logic [9:0] D = 10'h008;
  logic [1:0] SEL;
  logic       SEL_CHG;
  logic [9:0] F;

  alu_mode_controller #(
    .WIDTH(10),
    .DEBOUNCE_CYCLES(4),
    .SCAN_PERIOD(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BTN(BTN),
`ifdef ALU_MODE_AUTO_SCAN_EN
    .SCAN(SCAN),
`endif
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .SEL(SEL),
    .SEL_CHG(SEL_CHG),
    .F(F)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] btn;
    logic [1:0] sel;
    logic [9:0] f;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic       chg;
    logic [9:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   chg_count = 0;

  always @(posedge CLK) begin
    #1;
    if (SEL_CHG === 1'b1) chg_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic check_obs();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_sel"}, 32'(SEL), 32'(e.sel));
      chk({e.name, "_chg"}, 32'(SEL_CHG), 32'(e.chg));
      chk({e.name, "_f"}, 32'(F), 32'(e.f));
    end
  endtask

  task automatic mid_cycle_reset();
    #2 RST = 1'b1;
    #1;
    chk("async_rst_sel", 32'(SEL), 32'h0);
    chk("async_rst_f", 32'(F), 32'h0);
    chk("async_rst_chg", 32'(SEL_CHG), 32'h0);
    @(negedge CLK);
  endtask

  vec_t vecs[5];

  initial begin
    logic [1:0] prev_sel;
    logic [9:0] prev_f;

    vecs[0] = '{btn: 2'b01, sel: 2'b01, f: 10'h002};
    vecs[1] = '{btn: 2'b10, sel: 2'b11, f: 10'h008};
    vecs[2] = '{btn: 2'b11, sel: 2'b00, f: 10'h001};
    vecs[3] = '{btn: 2'b11, sel: 2'b11, f: 10'h008};
    vecs[4] = '{btn: 2'b01, sel: 2'b10, f: 10'h004};

    // Power-on reset
    @(negedge CLK);
    chk("por_sel", 32'(SEL), 32'h0);
    chk("por_chg", 32'(SEL_CHG), 32'h0);
    chk("por_f", 32'(F), 32'h0);
    RST = 1'b0;
    ticks(1);
    chk("por_first_f", 32'(F), 32'h001);

    prev_sel = 2'b00;
    prev_f   = 10'h001;
    for (int v = 0; v < 5; v++) begin
      chg_count = 0;
      BTN = vecs[v].btn;
      sb.push_back('{name: $sformatf("v%0d_pre", v), sel: prev_sel, chg: 1'b0, f: prev_f});
      sb.push_back('{name: $sformatf("v%0d_tog", v), sel: vecs[v].sel, chg: 1'b1, f: prev_f});
      sb.push_back('{name: $sformatf("v%0d_out", v), sel: vecs[v].sel, chg: 1'b0, f: vecs[v].f});
      ticks(6);
      check_obs();
      ticks(1);
      check_obs();
      ticks(1);
      check_obs();
      ticks(12);
      chk($sformatf("v%0d_held_sel", v), 32'(SEL), 32'(vecs[v].sel));
      chk($sformatf("v%0d_held_pulses", v), 32'(chg_count), 32'd1);
      BTN = 2'b00;
      ticks(10);
      chk($sformatf("v%0d_rel_sel", v), 32'(SEL), 32'(vecs[v].sel));
      chk($sformatf("v%0d_rel_pulses", v), 32'(chg_count), 32'd1);
      prev_sel = vecs[v].sel;
      prev_f   = vecs[v].f;
    end

    // Asynchronous reset between clock edges
    mid_cycle_reset();
    RST = 1'b0;
    ticks(1);
    chk("post_rst_f", 32'(F), 32'h001);
    chk("post_rst_sel", 32'(SEL), 32'h0);

    // Bounce on BTN[1]: 3 high, 1 low, 3 high, then released
    chg_count = 0;
    BTN = 2'b10; ticks(3);
    BTN = 2'b00; ticks(1);
    BTN = 2'b10; ticks(3);
    BTN = 2'b00; ticks(15);
    chk("bounce_sel", 32'(SEL), 32'h0);
    chk("bounce_pulses", 32'(chg_count), 32'd0);

    // Reset in the middle of a debounce count, button held through it
    BTN = 2'b01;
    ticks(4);
    mid_cycle_reset();
    ticks(1);
    chk("middb_rst_sel", 32'(SEL), 32'h0);
    RST = 1'b0;
    ticks(6);
    chk("middb_pre_sel", 32'(SEL), 32'h0);
    ticks(1);
    chk("middb_tog_sel", 32'(SEL), 32'h1);
    chk("middb_tog_chg", 32'(SEL_CHG), 32'h1);
    BTN = 2'b00;
    ticks(10);

`ifdef ALU_MODE_AUTO_SCAN_EN
    RST = 1'b1;
    ticks(1);
    RST  = 1'b0;
    SCAN = 1'b1;
    ticks(9);
    chk("scan_pre_sel", 32'(SEL), 32'h0);
    ticks(1);
    chk("scan_step1_sel", 32'(SEL), 32'h1);
    chk("scan_step1_chg", 32'(SEL_CHG), 32'h1);
    ticks(8);
    chk("scan_step2_sel", 32'(SEL), 32'h2);
    ticks(8);
    chk("scan_step3_sel", 32'(SEL), 32'h3);
    ticks(8);
    chk("scan_step4_sel", 32'(SEL), 32'h0);
    SCAN = 1'b0;
    ticks(4);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
